// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives the imem read address, and counts stall and redirect events.
module if_stage #(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_PC  = '0,
   parameter logic [31:0]      NOP_INSTR = 32'h0000_0013,
   parameter int               CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PCWrite,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [XLEN-1:0]  branch_target,
   output logic [XLEN-1:0]  imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [XLEN-1:0]  if_id_pc,
   output logic [31:0]      if_id_instr,
   output logic             if_id_valid,
   output logic [4:0]       if_id_rs1,
   output logic [4:0]       if_id_rs2,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  pc_nxt;
   logic [XLEN-1:0]  if_id_pc_nxt;
   logic [31:0]      if_id_instr_nxt;
   logic             if_id_valid_nxt;
   logic [CNT_W-1:0] stall_cnt_nxt;
   logic [CNT_W-1:0] flush_cnt_nxt;
   logic [XLEN-1:0]  pc_inc;
   logic [XLEN-1:0]  redirect_pc;

   assign pc_inc      = pc + XLEN'(4);
   assign redirect_pc = {branch_target[XLEN-1:2], 2'b00};

   always_comb begin
      pc_nxt          = pc;
      if_id_pc_nxt    = if_id_pc;
      if_id_instr_nxt = if_id_instr;
      if_id_valid_nxt = if_id_valid;
      stall_cnt_nxt   = stall_cnt;
      flush_cnt_nxt   = flush_cnt;
      if (stall) begin
         // Branch resolution is deferred: ID re-evaluates once the stall clears.
         if (PCWrite) begin
            pc_nxt = pc_inc;
         end
         if (stall_cnt != '1) begin
            stall_cnt_nxt = stall_cnt + CNT_W'(1);
         end
      end else if (branch_taken) begin
         if (PCWrite) begin
            pc_nxt = redirect_pc;
         end
         if_id_pc_nxt    = pc;
         if_id_instr_nxt = NOP_INSTR;
         if_id_valid_nxt = 1'b0;
         if (flush_cnt != '1) begin
            flush_cnt_nxt = flush_cnt + CNT_W'(1);
         end
      end else begin
         if (PCWrite) begin
            pc_nxt = pc_inc;
         end
         if_id_pc_nxt    = pc;
         if_id_instr_nxt = imem_rdata;
         if_id_valid_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         if_id_pc    <= '0;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         pc          <= pc_nxt;
         if_id_pc    <= if_id_pc_nxt;
         if_id_instr <= if_id_instr_nxt;
         if_id_valid <= if_id_valid_nxt;
         stall_cnt   <= stall_cnt_nxt;
         flush_cnt   <= flush_cnt_nxt;
      end
   end

   assign imem_addr = pc;
   assign if_id_rs1 = if_id_instr[19:15];
   assign if_id_rs2 = if_id_instr[24:20];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table plus hand sequences for saturation and reset.
// imem model returns the word index (addr>>2) as the instruction.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        PCWrite;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic [4:0]  if_id_rs1;
   logic [4:0]  if_id_rs2;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   logic [31:0] s_imem_addr;
   logic [31:0] s_imem_rdata;
   logic [31:0] s_if_id_pc;
   logic [31:0] s_if_id_instr;
   logic        s_if_id_valid;
   logic [4:0]  s_if_id_rs1;
   logic [4:0]  s_if_id_rs2;
   logic [3:0]  s_stall_cnt;
   logic [3:0]  s_flush_cnt;

   int total = 0;
   int bad   = 0;

   assign imem_rdata   = imem_addr >> 2;
   assign s_imem_rdata = s_imem_addr >> 2;

   if_stage dut (
      .clk(clk), .rst(rst), .PCWrite(PCWrite), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   if_stage #(.CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .PCWrite(PCWrite), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(s_imem_addr), .imem_rdata(s_imem_rdata),
      .if_id_pc(s_if_id_pc), .if_id_instr(s_if_id_instr), .if_id_valid(s_if_id_valid),
      .if_id_rs1(s_if_id_rs1), .if_id_rs2(s_if_id_rs2),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        pcw;
      logic        br;
      logic [31:0] tgt;
      logic [31:0] e_pc;
      logic [31:0] e_if_pc;
      logic [31:0] e_instr;
      logic        e_valid;
      logic [31:0] e_stall;
      logic [31:0] e_flush;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_if_pc,
                            input logic [31:0] e_instr, input logic e_valid,
                            input logic [31:0] e_stall, input logic [31:0] e_flush);
      chk({tag, " imem_addr"}, imem_addr, e_pc);
      chk({tag, " if_id_pc"}, if_id_pc, e_if_pc);
      chk({tag, " if_id_instr"}, if_id_instr, e_instr);
      chk({tag, " if_id_valid"}, 32'(if_id_valid), 32'(e_valid));
      chk({tag, " rs1"}, 32'(if_id_rs1), 32'(e_instr[19:15]));
      chk({tag, " rs2"}, 32'(if_id_rs2), 32'(e_instr[24:20]));
      chk({tag, " stall_cnt"}, stall_cnt, e_stall);
      chk({tag, " flush_cnt"}, flush_cnt, e_flush);
   endtask

   initial begin
      //          stall pcw br  tgt            pc             if_pc          instr          v  s  f
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h4,        32'h0,        32'h0,        1'b1, 0, 0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h8,        32'h4,        32'h1,        1'b1, 0, 0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'hC,        32'h8,        32'h2,        1'b1, 0, 0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hC,        32'h8,        32'h2,        1'b1, 1, 0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hC,        32'h8,        32'h2,        1'b1, 2, 0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h10,       32'hC,        32'h3,        1'b1, 2, 0};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h43,       32'h40,       32'h10,       NOP,          1'b0, 2, 1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h44,       32'h40,       32'h10,       1'b1, 2, 1};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h80,       32'h44,       32'h40,       32'h10,       1'b1, 3, 1};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h80,       32'h80,       32'h44,       NOP,          1'b0, 3, 2};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h100,      32'h80,       32'h80,       NOP,          1'b0, 3, 3};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h80,       32'h80,       32'h20,       1'b1, 3, 3};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h80,     NOP,          1'b0, 3, 4};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h3FFF_FFFF, 1'b1, 3, 4};

      rst = 1'b1;
      PCWrite = 1'b1;
      stall = 1'b0;
      branch_taken = 1'b0;
      branch_target = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_state("reset", 32'h0, 32'h0, NOP, 1'b0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         stall         = vecs[i].stall;
         PCWrite       = vecs[i].pcw;
         branch_taken  = vecs[i].br;
         branch_target = vecs[i].tgt;
         @(posedge clk);
         #1;
         chk_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_if_pc, vecs[i].e_instr,
                   vecs[i].e_valid, vecs[i].e_stall, vecs[i].e_flush);
         @(negedge clk);
      end

      // Saturation: 20 stall cycles on top of the 3 already counted.
      stall = 1'b1;
      PCWrite = 1'b0;
      branch_taken = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("sat small stall_cnt", 32'(s_stall_cnt), 32'hF);
      chk("sat small flush_cnt", 32'(s_flush_cnt), 32'h4);
      chk("sat wide stall_cnt", stall_cnt, 32'd23);
      chk("sat pc hold", imem_addr, 32'h0);

      // Reset asserted mid-stall, away from any edge.
      #2;
      rst = 1'b1;
      #1;
      chk_state("midrst", 32'h0, 32'h0, NOP, 1'b0, 0, 0);
      chk("midrst small stall_cnt", 32'(s_stall_cnt), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk_state("rst frozen", 32'h0, 32'h0, NOP, 1'b0, 0, 0);

      @(negedge clk);
      rst = 1'b0;
      stall = 1'b0;
      PCWrite = 1'b1;
      @(posedge clk);
      #1;
      chk_state("post rst", 32'h4, 32'h0, 32'h0, 1'b1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
